aud_i2s_stereo_tx: RTL and testbench

//  Parametrised stereo serializer for the WM8731 DAC path, clocked by codec BCLK in slave-to-codec timing.

---
 rtl/aud_pkg.sv | 6 +
 rtl/aud_frame_fifo.sv | 40 ++++
 rtl/aud_i2s_stereo_tx.sv | 90 +++++++++
 tb/tb_aud_i2s_stereo_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// aud_pkg: shared transmitter state type and framing-mode constants for the WM8731 DAC path
package aud_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_PAD} tx_state_e;
  localparam int AUD_MODE_I2S = 1;
  localparam int AUD_MODE_LJ = 0;
endpackage

// File: rtl/aud_frame_fifo.sv
// aud_frame_fifo: power-of-two stereo pair FIFO with exact occupancy; pushes while full are dropped
module aud_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               wr_data,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign rd_data = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two; level tracks push minus pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  // sample pair storage, no reset needed
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/aud_i2s_stereo_tx.sv
// aud_i2s_stereo_tx: stereo I2S/left-justified DACDAT serializer; AUD_TX_HOLD_LAST_EN replays the last pair on underrun
module aud_i2s_stereo_tx
  import aud_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int I2S_MODE = AUD_MODE_I2S
) (
  input  logic                               i_bclk,
  input  logic                               i_rst_n,
  input  logic                               i_daclrck,
  input  logic                               i_en,
  input  logic                               i_valid,
  input  logic [DATA_W-1:0]                  i_left,
  input  logic [DATA_W-1:0]                  i_right,
  output logic                               o_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_level,
  output logic                               o_underrun,
  output logic                               o_aud_dacdat
);
  localparam int CW = $clog2(DATA_W);
  tx_state_e state, state_nx;
  logic lrck_d, armed, silent, edge_det, ls, reload, pop, full, empty;
  logic [DATA_W-1:0] shift_r, hold_l, hold_r, hold_l_nx, hold_r_nx, sample;
  logic [CW-1:0] cnt_r;
  logic [2*DATA_W-1:0] fifo_q;

  aud_frame_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(i_bclk),
    .rst_n(i_rst_n),
    .push(i_valid),
    .pop(pop),
    .wr_data({i_left, i_right}),
    .rd_data(fifo_q),
    .full(full),
    .empty(empty),
    .level(o_level)
  );

  assign o_ready = !full;

  // state register
  always_ff @(posedge i_bclk or negedge i_rst_n)
    if (!i_rst_n) state <= TX_IDLE;
    else state <= state_nx;

  // edge decode, channel word selection, next state and serial output
  always_comb begin
    edge_det = armed && (i_daclrck != lrck_d);
    ls = edge_det && !i_daclrck;
    reload = ls || (edge_det && i_daclrck && state != TX_IDLE);
    pop = ls && i_en && !empty;
    hold_l_nx = hold_l;
    hold_r_nx = hold_r;
    if (pop) {hold_l_nx, hold_r_nx} = fifo_q;
`ifndef AUD_TX_HOLD_LAST_EN
    else if (ls && i_en) {hold_l_nx, hold_r_nx} = '0;
`endif
    sample = ls ? (i_en ? hold_l_nx : '0) : (silent ? '0 : hold_r);
    state_nx = reload ? TX_SHIFT : (state == TX_SHIFT && cnt_r == CW'(DATA_W-1)) ? TX_PAD : state;
    o_aud_dacdat = (I2S_MODE == AUD_MODE_LJ && reload) ? sample[DATA_W-1] : (state == TX_SHIFT) && shift_r[DATA_W-1];
  end

  // edge history, hold pair, shifter and underrun flag
  always_ff @(posedge i_bclk or negedge i_rst_n)
    if (!i_rst_n) begin
      lrck_d <= 1'b0;
      armed <= 1'b0;
      silent <= 1'b0;
      o_underrun <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      shift_r <= '0;
      cnt_r <= '0;
    end else begin
      lrck_d <= i_daclrck;
      armed <= 1'b1;
      o_underrun <= ls && i_en && empty;
      hold_l <= hold_l_nx;
      hold_r <= hold_r_nx;
      if (ls) silent <= !i_en;
      if (reload) begin
        shift_r <= (I2S_MODE == AUD_MODE_I2S) ? sample : sample << 1;
        cnt_r <= '0;
      end else if (state == TX_SHIFT) begin
        shift_r <= shift_r << 1;
        cnt_r <= cnt_r + 1'b1;
      end
    end
endmodule

// File: tb/tb_aud_i2s_stereo_tx.sv
// tb_aud_i2s_stereo_tx: drives an I2S and a left-justified instance with identical stimulus and checks both against a frame-level model
module tb_aud_i2s_stereo_tx;
  localparam int DW = 16;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH+1);
  localparam int NL = 4096;
`ifdef AUD_TX_HOLD_LAST_EN
  localparam logic [DW-1:0] UR_L = 16'hA5C3;
  localparam logic [DW-1:0] UR_R = 16'h0F0F;
`else
  localparam logic [DW-1:0] UR_L = 16'h0000;
  localparam logic [DW-1:0] UR_R = 16'h0000;
`endif

  logic clk = 0, rst_n = 0, lrck = 1, en = 0, valid = 0;
  logic [DW-1:0] left = 0, right = 0;
  logic rdy_i, rdy_j, ur_i, ur_j, dat_i, dat_j;
  logic [LW-1:0] lvl_i, lvl_j;
  int errors = 0, checks = 0, cyc = 0;
  logic log_i [NL];
  logic log_j [NL];
  logic log_u [NL];
  int log_l [NL];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aud_i2s_stereo_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .I2S_MODE(1)) u_i2s (
    .i_bclk(clk), .i_rst_n(rst_n), .i_daclrck(lrck), .i_en(en), .i_valid(valid),
    .i_left(left), .i_right(right), .o_ready(rdy_i), .o_level(lvl_i),
    .o_underrun(ur_i), .o_aud_dacdat(dat_i));

  aud_i2s_stereo_tx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .I2S_MODE(0)) u_lj (
    .i_bclk(clk), .i_rst_n(rst_n), .i_daclrck(lrck), .i_en(en), .i_valid(valid),
    .i_left(left), .i_right(right), .o_ready(rdy_j), .o_level(lvl_j),
    .o_underrun(ur_j), .o_aud_dacdat(dat_j));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic bit_of(input logic [DW-1:0] w, input int k);
    if (k < 0 || k >= DW) return 1'b0;
    return w[DW-1-k];
  endfunction

  // Model: a channel word loaded at an LRCK edge in cycle lc appears bit k at cycle lc+1+k (I2S) or lc+k (LJ)
  logic [2*DW-1:0] q[$];
  logic [DW-1:0] m_word = 0, last_l = 0, last_r = 0;
  int m_lc = 0;
  bit m_loaded = 0, m_silent = 0, m_armed = 0, m_prev = 0, m_ur = 0;

  always @(negedge clk) begin
    int sz0;
    bit ls, rs, edge_c;
    if (cyc < NL) begin
      log_i[cyc] = dat_i;
      log_j[cyc] = dat_j;
      log_u[cyc] = ur_i;
      log_l[cyc] = int'(lvl_i);
    end
    if (!rst_n) begin
      q.delete();
      m_loaded = 0; m_silent = 0; m_armed = 0; m_prev = 0; m_ur = 0;
      last_l = 0; last_r = 0;
      check("rst_dat_i2s", dat_i, 0);
      check("rst_dat_lj", dat_j, 0);
      check("rst_underrun", {ur_i, ur_j}, 0);
      check("rst_level", {lvl_i, lvl_j}, 0);
      check("rst_ready", {rdy_i, rdy_j}, 2'b11);
    end else begin
      sz0 = q.size();
      check("level_i2s", lvl_i, sz0);
      check("level_lj", lvl_j, sz0);
      check("ready_i2s", rdy_i, sz0 < DEPTH);
      check("ready_lj", rdy_j, sz0 < DEPTH);
      check("underrun_i2s", ur_i, m_ur);
      check("underrun_lj", ur_j, m_ur);
      check("dacdat_i2s", dat_i, m_loaded ? bit_of(m_word, cyc - m_lc - 1) : 1'b0);
      edge_c = m_armed && (lrck != m_prev);
      ls = edge_c && !lrck;
      rs = edge_c && lrck;
      m_ur = ls && en && sz0 == 0;
      if (ls) begin
        if (!en) begin
          m_word = 0;
          m_silent = 1;
        end else if (sz0 != 0) begin
          {last_l, last_r} = q.pop_front();
          m_word = last_l;
          m_silent = 0;
        end else begin
`ifdef AUD_TX_HOLD_LAST_EN
          m_word = last_l;
`else
          last_l = 0;
          last_r = 0;
          m_word = 0;
`endif
          m_silent = 0;
        end
        m_loaded = 1;
        m_lc = cyc;
      end else if (rs && m_loaded) begin
        m_word = m_silent ? '0 : last_r;
        m_lc = cyc;
      end
      check("dacdat_lj", dat_j, m_loaded ? bit_of(m_word, cyc - m_lc) : 1'b0);
      if (valid && sz0 < DEPTH) q.push_back({left, right});
      m_prev = lrck;
      m_armed = 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    valid = 1; left = l; right = r;
    tick();
    valid = 0;
  endtask

  task automatic half(input logic v, input int n);
    lrck = v;
    tick(n);
  endtask

  function automatic logic [DW-1:0] word_from(input bit lj, input int t0, input int n);
    logic [DW-1:0] w = '0;
    for (int i = 0; i < n; i++) w = {w[DW-2:0], lj ? log_j[t0+i] : log_i[t0+i]};
    return w;
  endfunction

  function automatic int ones(input bit lj, input int a, input int b);
    int s = 0;
    for (int i = a; i < b; i++) s += int'(lj ? log_j[i] : log_i[i]);
    return s;
  endfunction

  initial begin
    int tf, tr, t0;
    rst_n = 0; lrck = 1;
    tick(3);
    rst_n = 1;
    tick(2);
    // basic frame, both framings
    en = 1;
    push(16'hA5C3, 16'h0F0F);
    tick(2);
    tf = cyc; half(0, 32);
    tr = cyc; half(1, 32);
    check("t1_left_i2s", word_from(0, tf + 1, 16), 16'hA5C3);
    check("t1_pad_i2s", word_from(0, tf + 17, 15), 0);
    check("t1_right_i2s", word_from(0, tr + 1, 16), 16'h0F0F);
    check("t2_msb_on_edge_lj", log_j[tf], 1);
    check("t2_left_lj", word_from(1, tf, 16), 16'hA5C3);
    check("t2_level_pre_pop", log_l[tf], 1);
    check("t2_level_post_pop", log_l[tf + 1], 0);
    // empty FIFO: one underrun pulse per left frame
    t0 = cyc;
    tf = cyc; half(0, 16);
    tr = cyc; half(1, 16);
    half(0, 16); half(1, 16);
    check("t3_underrun_pulse", log_u[tf + 1], 1);
    check("t3_underrun_count", ones(0, 0, 0) + int'(log_u[tf]) + int'(log_u[tf + 2]), 0);
    begin
      int c = 0;
      for (int i = t0; i < cyc; i++) c += int'(log_u[i]);
      check("t3_underrun_total", c, 2);
    end
    check("t3_left_i2s", word_from(0, tf + 1, 16), UR_L);
    check("t3_right_lj", word_from(1, tr, 16), UR_R);
    // fill past capacity with LRCK idle
    for (int i = 1; i <= 5; i++) begin
      push(16'(i * 16'h1111), 16'(16'h1000 + i));
      if (i == 4) check("t4_ready_after_4th", rdy_i, 0);
    end
    check("t4_level_full", lvl_i, 4);
    check("t4_ready_full", rdy_j, 0);
    // disabled frame: silent, no pop, no flag
    en = 0;
    tf = cyc; half(0, 20); half(1, 20);
    check("t4_silent_level", lvl_i, 4);
    check("t4_silent_data", ones(0, tf, cyc) + ones(1, tf, cyc), 0);
    check("t4_silent_no_underrun", log_u[tf + 1], 0);
    en = 1;
    for (int i = 1; i <= 4; i++) begin
      tf = cyc; half(0, 20);
      tr = cyc; half(1, 20);
      check("t4_pop_left", word_from(0, tf + 1, 16), 16'(i * 16'h1111));
      check("t4_pop_right", word_from(1, tr, 16), 16'(16'h1000 + i));
    end
    check("t4_drained", lvl_j, 0);
    // short LRCK half-period truncates LSBs
    push(16'hBEEF, 16'h1234);
    tf = cyc; half(0, 8);
    tr = cyc; half(1, 8);
    half(0, 4);
    check("t5_left_trunc_i2s", word_from(0, tf + 1, 8), 8'hBE);
    check("t5_right_trunc_i2s", word_from(0, tr + 1, 8), 8'h12);
    check("t5_left_trunc_lj", word_from(1, tf, 8), 8'hBE);
    check("t5_right_trunc_lj", word_from(1, tr, 8), 8'h12);
    half(1, 8);
    // reset in the middle of a shifting word
    push(16'h5A5A, 16'h3C3C);
    push(16'h7E81, 16'h0001);
    half(0, 4);
    t0 = cyc;
    rst_n = 0;
    tick(3);
    rst_n = 1;
    push(16'hC0DE, 16'hFACE);
    half(1, 10);
    tf = cyc; half(0, 20);
    tr = cyc; half(1, 20);
    check("t6_quiet_i2s", ones(0, t0, tf + 1), 0);
    check("t6_quiet_lj", ones(1, t0, tf), 0);
    check("t6_left_i2s", word_from(0, tf + 1, 16), 16'hC0DE);
    check("t6_left_lj", word_from(1, tf, 16), 16'hC0DE);
    check("t6_right_i2s", word_from(0, tr + 1, 16), 16'hFACE);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
